l1_l2_arbiter: RTL and testbench
================================

# l1_l2_arbiter

Arbitrates the IL1 refill port and the DL1 refill/write-back port onto the single shared L2 request channel. It sits between the two L1 controllers and the L2 controller. It registers the winning request and drives the L2 handshake. It returns the fetched line and a one-cycle acknowledge to the owning L1. No new grant is issued while an L2 inclusive-invalidation sequence is in progress.

## Interface
- ADDR_W, 32, request address width
- LINE_W, 128, cache-line transfer width
- WAIT_LIMIT, 255, cycles in ARB_ISSUE+ARB_WAIT before timeout_err is flagged

Ports:
- clk_l1  in  1  clock; all state updates on negedge clk_l1
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  IL1 refill request; held until i_ack
- i_addr  in  ADDR_W  IL1 miss address
- d_req  in  1  DL1 request; held until d_ack
- d_wr  in  1  1 = DL1 write-back, 0 = DL1 refill
- d_addr  in  ADDR_W  DL1 address
- d_wdata  in  LINE_W  DL1 write-back line
- inv_busy  in  1  L2 inclusive invalidation active; blocks new grants
- i_ack  out  1  one-cycle pulse: IL1 transaction complete
- d_ack  out  1  one-cycle pulse: DL1 transaction complete
- rdata  out  LINE_W  returned line, valid while either ack is high
- grant_owner  out  2  00 none, 01 IL1, 10 DL1
- l2_req  out  1  request valid toward L2
- l2_wr  out  1  write-back flag
- l2_addr  out  ADDR_W  registered address
- l2_wdata  out  LINE_W  registered write data
- l2_ready  in  1  L2 accepts the request when l2_req && l2_ready
- l2_done  in  1  L2 transaction finished; l2_rdata valid
- l2_rdata  in  LINE_W  L2 read line
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
- ARB_IDLE: if !inv_busy and (i_req || d_req), select a winner and capture its address, wr and wdata into registers. IL1 wr = 0, wdata = 0. Set grant_owner. Go to ARB_ISSUE. Otherwise stay.
- Selection: a single requester wins. If both request, the winner is the one not granted last (last_grant register). last_grant resets to DL1, so the first tie goes to IL1.
- ARB_ISSUE: l2_req = 1 with the registered fields. When l2_ready is sampled high, go to ARB_WAIT. l2_done in this state is ignored.
- ARB_WAIT: l2_req = 0. When l2_done is high, latch l2_rdata into rdata (write-backs latch as well; the value is don't-care to DL1). Go to ARB_RESP.
- ARB_RESP: pulse the owner's ack for exactly one cycle and update last_grant. Go to ARB_IDLE; grant_owner returns to 00 on this transition.
- The requester drops req before the next negedge after its ack. A req still high in ARB_IDLE is treated as a new request.
- inv_busy affects only new grants. A transaction already in progress completes regardless.
- Watchdog: a cycle counter clears on entering ARB_ISSUE and counts in ARB_ISSUE/ARB_WAIT, saturating at WAIT_LIMIT. On reaching WAIT_LIMIT, timeout_err sets and stays set until reset. The FSM keeps waiting and does not abort.
- Request inputs change only while req is low. The arbiter samples the fields only at grant.

## Timing
- Reset (asynchronous): FSM to ARB_IDLE; last_grant = DL1; counter = 0. All outputs are 0, including rdata and timeout_err. l2_req drops immediately.
- A reset mid-transaction abandons the transaction with no ack. The L2 is reset by the same rst_n.
- Minimum latency, with l2_ready and l2_done high as early as possible:
  - edge 0: ARB_IDLE → ARB_ISSUE
  - edge 1: ARB_ISSUE → ARB_WAIT
  - edge 2: ARB_WAIT → ARB_RESP; ack visible
  - edge 3: → ARB_IDLE
  - A 4-edge grant-to-idle turnaround; the next grant can occur at edge 4.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package RVS192_package gets:
  - arb_state_t enum (2-bit)
  - arb_owner_t (2-bit, ARB_NONE/ARB_IL1/ARB_DL1)
  - default WAIT_LIMIT constant
- Sub-module l2_arb_rr_picker: combinational 2-way round-robin selection from i_req, d_req and last_grant, producing the winner. last_grant is registered in the parent.

## Test plan
- Single IL1 request, i_addr=0x0000_1040, l2_ready tied high, l2_done after 3 cycles in ARB_WAIT with l2_rdata=0xDEAD…BEEF -> l2_addr=0x1040, l2_wr=0; i_ack pulses one cycle with rdata=0xDEAD…BEEF; grant_owner 01 then 00.
- Simultaneous i_req and d_req (d_wr=1, d_addr=0x2000) from reset -> IL1 served first. After i_ack, DL1 is granted with l2_wr=1 and l2_wdata=d_wdata. Next tie goes to IL1 again.
- inv_busy=1 while i_req is high for 5 cycles -> l2_req stays 0 and grant_owner stays 00. Grant occurs on the first negedge after inv_busy falls.
- l2_ready held low 10 cycles -> l2_req and l2_addr stay stable. A l2_done pulse during ARB_ISSUE is ignored; no ack is produced.
- WAIT_LIMIT=8, l2_done never asserted -> timeout_err rises after 8 cycles in ARB_ISSUE/ARB_WAIT and stays high. A later l2_done still produces the ack.
- rst_n asserted in ARB_WAIT -> l2_req, acks, rdata and grant_owner go to 0 immediately. FSM is in ARB_IDLE after release. No ack for the abandoned request.

Source files
------------

// File: rtl/RVS192_package.sv
// Shared types and defaults for the L1/L2 request arbiter.
package RVS192_package;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_NONE = 2'b00,
    ARB_IL1  = 2'b01,
    ARB_DL1  = 2'b10
  } arb_owner_t;

  localparam int ARB_WAIT_LIMIT_DEF = 255;

  // The requester that should win a tie, given who was served last.
  function automatic arb_owner_t arb_other(input arb_owner_t last);
    return (last == ARB_IL1) ? ARB_DL1 : ARB_IL1;
  endfunction

endpackage

// File: rtl/l2_arb_rr_picker.sv
// Two-way round-robin winner selection between the IL1 and DL1 request lines.
module l2_arb_rr_picker
  import RVS192_package::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output arb_owner_t winner
);

  always_comb begin
    winner = ARB_NONE;
    if (i_req && d_req) begin
      winner = arb_other(last_grant);
    end else if (i_req) begin
      winner = ARB_IL1;
    end else if (d_req) begin
      winner = ARB_DL1;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 request channel between the IL1 refill and DL1 refill/write-back ports.
//   state     | meaning
//   ARB_IDLE  | no owner; grant when a request is pending and no invalidation runs
//   ARB_ISSUE | l2_req high with the captured fields, waiting for l2_ready
//   ARB_WAIT  | request accepted, waiting for l2_done to latch the line
//   ARB_RESP  | one-cycle ack to the owner, last_grant updated
module l1_l2_arbiter
  import RVS192_package::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int WAIT_LIMIT = ARB_WAIT_LIMIT_DEF
) (
  input  logic              clk_l1,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              inv_busy,
  output logic              i_ack,
  output logic              d_ack,
  output logic [LINE_W-1:0] rdata,
  output logic [1:0]        grant_owner,
  output logic              l2_req,
  output logic              l2_wr,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_ready,
  input  logic              l2_done,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              timeout_err
);

  localparam int                CNT_W   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WAIT_LIMIT);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  arb_owner_t        winner;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              l2_req_q, l2_req_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

  l2_arb_rr_picker u_picker (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_q),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      ARB_IDLE: begin
        if (!inv_busy && (winner != ARB_NONE)) begin
          state_d = ARB_ISSUE;
          owner_d = winner;
          cnt_d   = '0;
          if (winner == ARB_IL1) begin
            addr_d  = i_addr;
            wr_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = d_addr;
            wr_d    = d_wr;
            wdata_d = d_wdata;
          end
        end
      end
      ARB_ISSUE: begin
        if (l2_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (l2_done) begin
          rdata_d = l2_rdata;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        last_d  = owner_q;
        owner_d = ARB_NONE;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Watchdog only observes; a slow L2 is flagged but never aborted.
    if ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) timeout_d = 1'b1;
    end

    l2_req_d = (state_d == ARB_ISSUE);
    i_ack_d  = (state_d == ARB_RESP) && (owner_d == ARB_IL1);
    d_ack_d  = (state_d == ARB_RESP) && (owner_d == ARB_DL1);
  end

  always_ff @(negedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_NONE;
      last_q    <= ARB_DL1;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      l2_req_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      l2_req_q  <= l2_req_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign rdata       = rdata_q;
  assign grant_owner = owner_q;
  assign l2_req      = l2_req_q;
  assign l2_wr       = wr_q;
  assign l2_addr     = addr_q;
  assign l2_wdata    = wdata_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench for l1_l2_arbiter: randomized L1 traffic and L2 latency plus directed corner cases.
module tb_l1_l2_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int WL = 8;

  typedef struct {
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [1:0]    owner;
    logic [LW-1:0] rdata;
  } ack_exp_t;

  logic          clk_l1 = 1'b1;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          inv_busy = 1'b0;
  logic          l2_ready = 1'b0;
  logic          l2_done = 1'b0;
  logic [LW-1:0] l2_rdata = '0;
  logic          i_ack, d_ack, l2_req, l2_wr, timeout_err;
  logic [LW-1:0] rdata, l2_wdata;
  logic [1:0]    grant_owner;
  logic [AW-1:0] l2_addr;

  req_exp_t      req_q[$];
  ack_exp_t      ack_q[$];
  logic [LW-1:0] l2_data_q[$];

  int tests = 0;
  int fails = 0;
  int last_win = 2;           // 1 = IL1, 2 = DL1 served last
  bit auto_l2 = 1'b0;
  int rdy_lo = 0, rdy_hi = 0, done_lo = 0, done_hi = 0;

  always #5 clk_l1 = ~clk_l1;

  l1_l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .WAIT_LIMIT(WL)) dut (
    .clk_l1(clk_l1), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .inv_busy(inv_busy),
    .i_ack(i_ack), .d_ack(d_ack), .rdata(rdata), .grant_owner(grant_owner),
    .l2_req(l2_req), .l2_wr(l2_wr), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ready(l2_ready), .l2_done(l2_done), .l2_rdata(l2_rdata),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request-side monitor: every new l2_req must match the next expected transaction.
  logic prev_l2_req = 1'b0;
  initial begin
    req_exp_t e;
    forever begin
      @(posedge clk_l1);
      if (l2_req && !prev_l2_req) begin
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_unexpected: got l2_addr %0h expected no request", l2_addr);
        end else begin
          e = req_q.pop_front();
          check("req_owner", grant_owner, e.owner);
          check("req_addr", l2_addr, e.addr);
          check("req_wr", l2_wr, e.wr);
          check("req_wdata", l2_wdata, e.wdata);
        end
      end
      prev_l2_req = l2_req;
    end
  end

  // Ack-side monitor: every ack must match the next expected completion.
  initial begin
    ack_exp_t e;
    logic [1:0] who;
    forever begin
      @(posedge clk_l1);
      if (i_ack || d_ack) begin
        who = {d_ack, i_ack};
        if (ack_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ack_unexpected: got acks %0b expected none", who);
        end else begin
          e = ack_q.pop_front();
          check("ack_owner", who, e.owner);
          check("ack_grant_owner", grant_owner, e.owner);
          check("ack_rdata", rdata, e.rdata);
        end
      end
    end
  end

  // L2 responder with randomized ready/done latency.
  initial begin
    int n;
    forever begin
      @(posedge clk_l1);
      if (auto_l2 && l2_req && rst_n) begin
        repeat ($urandom_range(rdy_lo, rdy_hi)) @(posedge clk_l1);
        l2_ready = 1'b1;
        n = 0;
        while (l2_req && n < 50) begin
          @(posedge clk_l1);
          n++;
        end
        l2_ready = 1'b0;
        repeat ($urandom_range(done_lo, done_hi)) @(posedge clk_l1);
        l2_rdata = (l2_data_q.size() > 0) ? l2_data_q.pop_front() : '0;
        l2_done = 1'b1;
        @(posedge clk_l1);
        l2_done = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    @(posedge clk_l1);
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; inv_busy = 1'b0;
    #1;
    check("rst_l2_req", l2_req, 0);
    check("rst_grant_owner", grant_owner, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_l2_addr", l2_addr, 0);
    repeat (2) @(posedge clk_l1);
    rst_n = 1'b1;
    last_win = 2;
  endtask

  task automatic wait_acks();
    int budget = 0;
    while ((i_req || d_req) && budget < 150) begin
      @(posedge clk_l1);
      budget++;
      if (!auto_l2) l2_done = 1'b0;
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    if (i_req || d_req) begin
      tests++; fails++;
      $display("FAIL ack_timeout: got reqs %0b still pending expected 00", {d_req, i_req});
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  function automatic void push_txn(input int own, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                   input logic dw, input logic [LW-1:0] dwd, input logic [LW-1:0] rd);
    req_exp_t r;
    ack_exp_t a;
    r.owner = own[1:0];
    r.addr  = (own == 1) ? ia : da;
    r.wr    = (own == 1) ? 1'b0 : dw;
    r.wdata = (own == 1) ? '0 : dwd;
    a.owner = own[1:0];
    a.rdata = rd;
    req_q.push_back(r);
    ack_q.push_back(a);
    l2_data_q.push_back(rd);
  endfunction

  // Reference model: ties go to whoever was not served last; order follows that rule.
  task automatic do_round(input bit want_i, input bit want_d, input logic [AW-1:0] ia,
                          input logic [AW-1:0] da, input logic dw, input logic [LW-1:0] dwd,
                          input logic [LW-1:0] rd0, input logic [LW-1:0] rd1, input int inv_cyc);
    int first, second;
    first  = (want_i && want_d) ? ((last_win == 2) ? 1 : 2) : (want_i ? 1 : 2);
    second = 3 - first;
    push_txn(first, ia, da, dw, dwd, rd0);
    last_win = first;
    if (want_i && want_d) begin
      push_txn(second, ia, da, dw, dwd, rd1);
      last_win = second;
    end
    @(posedge clk_l1);
    inv_busy = (inv_cyc > 0);
    i_req = want_i; i_addr = ia;
    d_req = want_d; d_addr = da; d_wr = dw; d_wdata = dwd;
    for (int k = 0; k < inv_cyc; k++) begin
      @(posedge clk_l1);
      check("inv_l2_req", l2_req, 0);
      check("inv_grant_owner", grant_owner, 0);
    end
    if (inv_cyc > 0) begin
      inv_busy = 1'b0;
      @(posedge clk_l1);
      check("inv_release_owner", grant_owner, first[1:0]);
      check("inv_release_l2_req", l2_req, 1);
    end
    wait_acks();
    @(posedge clk_l1);
    check("idle_owner", grant_owner, 0);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [LW-1:0] rd;
    int pat, inv;

    do_reset();
    auto_l2 = 1'b1;

    // Single IL1 refill, done three cycles into the wait.
    rdy_lo = 0; rdy_hi = 0; done_lo = 2; done_hi = 2;
    do_round(1'b1, 1'b0, 32'h0000_1040, 32'h0, 1'b0, '0,
             128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, '0, 0);

    // Ties from reset: IL1 first, then DL1 write-back, then IL1 again.
    do_reset();
    done_lo = 0; done_hi = 0;
    do_round(1'b1, 1'b1, 32'h0000_5000, 32'h0000_2000, 1'b1, rnd_line(), rnd_line(), rnd_line(), 0);
    do_round(1'b1, 1'b1, 32'h0000_6000, 32'h0000_2040, 1'b0, rnd_line(), rnd_line(), rnd_line(), 0);

    // Invalidation holds off the grant for five cycles.
    do_round(1'b1, 1'b0, 32'h0000_7000, 32'h0, 1'b0, '0, rnd_line(), '0, 5);

    rdy_lo = 0; rdy_hi = 2; done_lo = 0; done_hi = 3;
    for (int r = 0; r < 40; r++) begin
      pat = $urandom_range(1, 3);
      inv = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_round(pat[0], pat[1], $urandom, $urandom, 1'($urandom_range(0, 1)),
               rnd_line(), rnd_line(), rnd_line(), inv);
    end
    check("no_timeout_random", timeout_err, 0);

    // Stalled l2_ready: stable request, ignored early done, watchdog at WL cycles.
    auto_l2 = 1'b0;
    do_reset();
    rd = rnd_line();
    push_txn(1, 32'h0000_ABC0, 32'h0, 1'b0, '0, rd);
    void'(l2_data_q.pop_back());
    last_win = 1;
    @(posedge clk_l1);
    i_req = 1'b1; i_addr = 32'h0000_ABC0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_l1);
      check("stall_l2_req", l2_req, 1);
      check("stall_l2_addr", l2_addr, 32'h0000_ABC0);
      check("stall_timeout", timeout_err, (k >= 9) ? 1 : 0);
      if (k == 5) begin l2_done = 1'b1; l2_rdata = ~rd; end
      if (k == 6) l2_done = 1'b0;
      if (k == 10) l2_ready = 1'b1;
    end
    @(posedge clk_l1);
    l2_ready = 1'b0;
    check("accepted_l2_req", l2_req, 0);
    repeat (2) @(posedge clk_l1);
    l2_done = 1'b1; l2_rdata = rd;
    wait_acks();
    l2_done = 1'b0;
    @(posedge clk_l1);
    check("timeout_sticky", timeout_err, 1);

    // Reset while waiting on L2 abandons the transaction.
    req_q.push_back('{owner: 2'd2, addr: 32'h0000_3000, wr: 1'b1, wdata: 128'h55AA});
    @(posedge clk_l1);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_3000; d_wdata = 128'h55AA;
    @(posedge clk_l1);
    l2_ready = 1'b1;
    @(posedge clk_l1);
    l2_ready = 1'b0;
    check("wait_l2_req", l2_req, 0);
    check("wait_owner", grant_owner, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_l2_req", l2_req, 0);
    check("midrst_acks", {i_ack, d_ack}, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_owner", grant_owner, 0);
    check("midrst_timeout", timeout_err, 0);
    d_req = 1'b0;
    repeat (2) @(posedge clk_l1);
    rst_n = 1'b1;
    last_win = 2;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_l1);
      check("post_rst_owner", grant_owner, 0);
      check("post_rst_l2_req", l2_req, 0);
    end
    auto_l2 = 1'b1;
    do_round(1'b1, 1'b1, 32'h0000_8000, 32'h0000_9000, 1'b0, rnd_line(), rnd_line(), rnd_line(), 0);

    repeat (3) @(posedge clk_l1);
    check("req_queue_empty", req_q.size(), 0);
    check("ack_queue_empty", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
